// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared constants and types for the register-file write-back arbiter.
//   AW/DW/NREG : default register index width, data width, register count
//   grant_e    : per-cycle owner of the single RF write port
package rf_wb_pkg;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_MCU  = 2'd2
  } grant_e;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: bundles the WB-arbiter bus signals.
//   pipe_*  : pipeline WB write request
//   mcu_*   : multi-cycle unit issue notification and result handshake
//   dec_*   : decode-stage register indices checked for hazards
//   hazard_stall / pipe_stall / busy_mask : stall and scoreboard outputs
//   rf_*    : registered RF write port
// Modports: master = environment driving requests, slave = arbiter.
interface rf_wb_arbiter_if #(
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int NREG = 32
);
  logic            pipe_we;
  logic [AW-1:0]   pipe_wr;
  logic [DW-1:0]   pipe_wd;
  logic            mcu_issue;
  logic [AW-1:0]   mcu_issue_rd;
  logic            mcu_valid;
  logic [AW-1:0]   mcu_rd;
  logic [DW-1:0]   mcu_wd;
  logic            mcu_ready;
  logic [AW-1:0]   dec_rs1;
  logic [AW-1:0]   dec_rs2;
  logic [AW-1:0]   dec_rd;
  logic            hazard_stall;
  logic            pipe_stall;
  logic [NREG-1:0] busy_mask;
  logic            rf_we;
  logic [AW-1:0]   rf_wr;
  logic [DW-1:0]   rf_wd;

  modport master (
    output pipe_we, pipe_wr, pipe_wd,
    output mcu_issue, mcu_issue_rd, mcu_valid, mcu_rd, mcu_wd,
    output dec_rs1, dec_rs2, dec_rd,
    input  mcu_ready, hazard_stall, pipe_stall, busy_mask,
    input  rf_we, rf_wr, rf_wd
  );

  modport slave (
    input  pipe_we, pipe_wr, pipe_wd,
    input  mcu_issue, mcu_issue_rd, mcu_valid, mcu_rd, mcu_wd,
    input  dec_rs1, dec_rs2, dec_rd,
    output mcu_ready, hazard_stall, pipe_stall, busy_mask,
    output rf_we, rf_wr, rf_wd
  );
endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: busy bit per architectural register for outstanding MCU writes.
//   clk, rst          : clock, synchronous active-high reset
//   set_en/set_idx    : mark a register busy (MCU issue)
//   clr_en/clr_idx    : clear a register (MCU result transfer)
//   rs1/rs2/rd        : decode read ports
//   busy              : current scoreboard
//   hazard            : any read port hits a busy register
module rf_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  logic [AW-1:0]   set_idx,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_idx,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   rd,
  output logic [NREG-1:0] busy,
  output logic            hazard
);
  logic [NREG-1:0] busy_d, busy_q;

  // Clear first so a same-cycle set on the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // From the registered mask: a bit clearing this cycle still stalls.
  assign hazard = busy_q[rs1] | busy_q[rs2] | busy_q[rd];
  assign busy   = busy_q;
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the single RF write port between the pipeline WB stage
// and the multi-cycle unit, and tracks MCU destinations for decode hazards.
//   clk, rst : clock, synchronous active-high reset
//   bus      : rf_wb_arbiter_if.slave (pipe_*, mcu_*, dec_* in; mcu_ready,
//              hazard_stall, pipe_stall, busy_mask, rf_* out)
// Optional: define WB_STARVE_GUARD_EN to add an MCU starvation counter that
// forces an MCU grant and freezes the pipeline for one cycle.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int NREG         = rf_wb_pkg::NREG,
  parameter int AW           = rf_wb_pkg::AW,
  parameter int DW           = rf_wb_pkg::DW,
  parameter int STARVE_LIMIT = 4
) (
  input logic             clk,
  input logic             rst,
  rf_wb_arbiter_if.slave  bus
);
  grant_e          grant;
  logic            force_mcu;
  logic            pipe_req;
  logic            mcu_xfer;

  logic            rf_we_d, rf_we_q;
  logic [AW-1:0]   rf_wr_d, rf_wr_q;
  logic [DW-1:0]   rf_wd_d, rf_wd_q;

  // Writes to x0 never claim the port.
  assign pipe_req = bus.pipe_we & (bus.pipe_wr != '0);

`ifdef WB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_d, starve_q;

  always_comb begin
    starve_d = starve_q;
    if (!bus.mcu_valid || mcu_xfer)        starve_d = '0;
    else if (starve_q != CW'(STARVE_LIMIT)) starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

  assign force_mcu = bus.mcu_valid & (starve_q == CW'(STARVE_LIMIT));
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign force_mcu = 1'b0;
`endif

  always_comb begin
    grant = GNT_NONE;
    if (force_mcu)          grant = GNT_MCU;
    else if (pipe_req)      grant = GNT_PIPE;
    else if (bus.mcu_valid) grant = GNT_MCU;
  end

  assign bus.mcu_ready  = (grant == GNT_MCU);
  assign bus.pipe_stall = force_mcu;
  assign mcu_xfer       = bus.mcu_valid & bus.mcu_ready;

  // Address/data only move on a real write; idle cycles hold the last values.
  always_comb begin
    rf_we_d = 1'b0;
    rf_wr_d = rf_wr_q;
    rf_wd_d = rf_wd_q;
    if (grant == GNT_PIPE) begin
      rf_we_d = 1'b1;
      rf_wr_d = bus.pipe_wr;
      rf_wd_d = bus.pipe_wd;
    end else if (grant == GNT_MCU && bus.mcu_rd != '0) begin
      rf_we_d = 1'b1;
      rf_wr_d = bus.mcu_rd;
      rf_wd_d = bus.mcu_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q <= 1'b0;
      rf_wr_q <= '0;
      rf_wd_q <= '0;
    end else begin
      rf_we_q <= rf_we_d;
      rf_wr_q <= rf_wr_d;
      rf_wd_q <= rf_wd_d;
    end
  end

  assign bus.rf_we = rf_we_q;
  assign bus.rf_wr = rf_wr_q;
  assign bus.rf_wd = rf_wd_q;

  rf_scoreboard #(.NREG(NREG), .AW(AW)) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (bus.mcu_issue & (bus.mcu_issue_rd != '0)),
    .set_idx (bus.mcu_issue_rd),
    .clr_en  (mcu_xfer),
    .clr_idx (bus.mcu_rd),
    .rs1     (bus.dec_rs1),
    .rs2     (bus.dec_rs2),
    .rd      (bus.dec_rd),
    .busy    (bus.busy_mask),
    .hazard  (bus.hazard_stall)
  );
endmodule
